// File: rtl/fir_pkg.sv
// Shared widths, limits and the controller state encoding for the FIR block.
package fir_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned TAPS_MAX = 64;
    localparam int unsigned ACC_W    = 38;
    localparam int unsigned TAPS_W   = 7;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        WRITE,
        FIN
    } fir_state_t;

endpackage

// File: rtl/fir_if.sv
// Control, status and RAM-port bundle between the FIR controller and its surroundings.
interface fir_if #(
    parameter int unsigned ADDR_W = fir_pkg::ADDR_W,
    parameter int unsigned DATA_W = fir_pkg::DATA_W
);
    import fir_pkg::*;

    logic                start;
    logic [ADDR_W-1:0]   num_samples;
    logic [TAPS_W-1:0]   num_taps;
    logic                busy;
    logic                done;
    logic                sat;
    logic                sel_FSM_mux_wej;
    logic [ADDR_W-1:0]   probka_addr;
    logic [DATA_W-1:0]   probka;
    logic [ADDR_W-1:0]   wsp_addr;
    logic [DATA_W-1:0]   wsp;
    logic [ADDR_W-1:0]   wyj_addr;
    logic [DATA_W-1:0]   wyj_data;
    logic                wyj_wr;

    // Host / RAM side
    modport master (
        output start, num_samples, num_taps, probka, wsp,
        input  busy, done, sat, sel_FSM_mux_wej, probka_addr, wsp_addr,
               wyj_addr, wyj_data, wyj_wr
    );

    // Filter controller side
    modport slave (
        input  start, num_samples, num_taps, probka, wsp,
        output busy, done, sat, sel_FSM_mux_wej, probka_addr, wsp_addr,
               wyj_addr, wyj_data, wyj_wr
    );

endinterface

// File: rtl/fir_mac.sv
// Signed Q1.15 multiply-accumulate with round-half-up and 16-bit saturation.
module fir_mac #(
    parameter int unsigned DATA_W = fir_pkg::DATA_W,
    parameter int unsigned ACC_W  = fir_pkg::ACC_W
) (
    input  logic                     a_clk,
    input  logic                     a_rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] h,
    output logic        [DATA_W-1:0] res,
    output logic                     ovf
);
    import fir_pkg::*;

    localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (DATA_W - 2);

    logic signed [2*DATA_W-1:0]   prod;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      acc_next;
    logic signed [ACC_W-1:0]      rnd;
    logic        [ACC_W-DATA_W:0] top;

    // Product, next accumulator value, and the rounded/saturated view of it.
    always_comb begin
        prod     = x * h;
        acc_next = en ? acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod} : acc;
        rnd      = $signed(acc_next + RND_BIAS) >>> (DATA_W - 1);
        top      = rnd[ACC_W-1:DATA_W-1];
        ovf      = !((&top) || !(|top));
        res      = rnd[DATA_W-1:0];
        if (ovf) begin
            res = rnd[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // Running sum for the output sample currently being computed.
    always_ff @(posedge a_clk) begin
        if (a_rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/fir_ctrl.sv
// Block FIR controller: walks n over the block and k over the taps, drives the
// input/coefficient RAM addresses and writes rounded results to the output RAM.
module fir_ctrl #(
    parameter int unsigned TAPS_MAX = fir_pkg::TAPS_MAX,
    parameter int unsigned ADDR_W   = fir_pkg::ADDR_W,
    parameter int unsigned DATA_W   = fir_pkg::DATA_W
) (
    input  logic a_clk,
    input  logic a_rst,
    fir_if.slave bus
);
    import fir_pkg::*;

    fir_state_t          state;
    logic [ADDR_W-1:0]   n_len;
    logic [ADDR_W-1:0]   n_cnt;
    logic [ADDR_W-1:0]   n_nxt;
    logic [TAPS_W-1:0]   t_len;
    logic [TAPS_W-1:0]   t_eff;
    logic [TAPS_W-1:0]   k_cnt;
    logic [TAPS_W-1:0]   k_nxt;
    logic                tap_live;
    logic                live_nxt;
    logic                mac_en;
    logic                ovf_q;
    logic                accept;
    logic                acc_clr;
    logic                k_last;
    logic                n_last;
    logic [DATA_W-1:0]   mac_res;
    logic                mac_ovf;

    // Tap/sample bookkeeping and the accumulator clear strobe.
    always_comb begin
        accept   = (state == IDLE) && bus.start;
        t_eff    = (bus.num_taps > TAPS_W'(TAPS_MAX)) ? TAPS_W'(TAPS_MAX) : bus.num_taps;
        k_nxt    = k_cnt + 1'b1;
        live_nxt = (ADDR_W'(k_nxt) <= n_cnt);
        k_last   = (k_cnt == t_len - 1'b1);
        n_last   = (n_cnt == n_len - 1'b1);
        n_nxt    = n_cnt + 1'b1;
        acc_clr  = accept || (state == WRITE);
    end

    fir_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .a_clk (a_clk),
        .a_rst (a_rst),
        .clr   (acc_clr),
        .en    (mac_en),
        .x     (bus.probka),
        .h     (bus.wsp),
        .res   (mac_res),
        .ovf   (mac_ovf)
    );

    // Sequencer: addresses for tap k go out in MAC, their product is summed one
    // cycle later (mac_en), so DRAIN absorbs the last tap before WRITE.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state               <= IDLE;
            n_len               <= '0;
            n_cnt               <= '0;
            t_len               <= '0;
            k_cnt               <= '0;
            tap_live            <= 1'b0;
            mac_en              <= 1'b0;
            ovf_q               <= 1'b0;
            bus.busy            <= 1'b0;
            bus.sel_FSM_mux_wej <= 1'b0;
            bus.done            <= 1'b0;
            bus.sat             <= 1'b0;
            bus.probka_addr     <= '0;
            bus.wsp_addr        <= '0;
            bus.wyj_addr        <= '0;
            bus.wyj_data        <= '0;
            bus.wyj_wr          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_len           <= bus.num_samples;
                        t_len           <= t_eff;
                        n_cnt           <= '0;
                        k_cnt           <= '0;
                        tap_live        <= 1'b1;
                        bus.sat         <= 1'b0;
                        bus.probka_addr <= '0;
                        bus.wsp_addr    <= '0;
                        if (bus.num_samples == '0 || t_eff == '0) begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                        end else begin
                            state               <= MAC;
                            bus.busy            <= 1'b1;
                            bus.sel_FSM_mux_wej <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    mac_en <= tap_live;
                    if (k_last) begin
                        state <= DRAIN;
                    end else begin
                        k_cnt           <= k_nxt;
                        tap_live        <= live_nxt;
                        bus.wsp_addr    <= ADDR_W'(k_nxt);
                        bus.probka_addr <= live_nxt ? n_cnt - ADDR_W'(k_nxt) : '0;
                    end
                end
                DRAIN: begin
                    mac_en       <= 1'b0;
                    ovf_q        <= mac_ovf;
                    bus.wyj_wr   <= 1'b1;
                    bus.wyj_addr <= n_cnt;
                    bus.wyj_data <= mac_res;
                    state        <= WRITE;
                end
                WRITE: begin
                    bus.wyj_wr <= 1'b0;
                    if (ovf_q) begin
                        bus.sat <= 1'b1;
                    end
                    if (n_last) begin
                        state               <= FIN;
                        bus.busy            <= 1'b0;
                        bus.sel_FSM_mux_wej <= 1'b0;
                        bus.done            <= 1'b1;
                        bus.probka_addr     <= '0;
                        bus.wsp_addr        <= '0;
                    end else begin
                        n_cnt           <= n_nxt;
                        k_cnt           <= '0;
                        tap_live        <= 1'b1;
                        bus.probka_addr <= n_nxt;
                        bus.wsp_addr    <= '0;
                        state           <= MAC;
                    end
                end
                FIN: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl with behavioural input/coefficient RAMs and an
// output-RAM write logger.
module tb_fir_ctrl;
    import fir_pkg::*;

    logic a_clk = 1'b0;
    logic a_rst = 1'b1;

    fir_if #(.ADDR_W(13), .DATA_W(16)) bus ();

    fir_ctrl #(
        .TAPS_MAX (64),
        .ADDR_W   (13),
        .DATA_W   (16)
    ) dut (
        .a_clk (a_clk),
        .a_rst (a_rst),
        .bus   (bus)
    );

    always #5 a_clk = ~a_clk;

    logic [15:0] xmem [0:63];
    logic [15:0] hmem [0:63];

    int checks   = 0;
    int failures = 0;

    int ecnt     = 0;
    int e0       = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int inv_err  = 0;
    int cur_n    = 0;
    logic [12:0] wr_addr [0:63];
    logic [15:0] wr_data [0:63];
    int          wr_cyc  [0:63];

    // Synchronous-read RAM models
    always @(posedge a_clk) begin
        bus.probka <= xmem[bus.probka_addr[5:0]];
        bus.wsp    <= hmem[bus.wsp_addr[5:0]];
    end

    // Edge counter; remembers the edge at which a start is accepted
    always @(posedge a_clk) begin
        if (bus.start && !bus.busy && !a_rst) e0 = ecnt;
        ecnt = ecnt + 1;
    end

    // Output-RAM logger and running invariants, sampled mid-cycle
    always @(negedge a_clk) begin
        if (bus.wyj_wr === 1'b1) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = bus.wyj_addr;
                wr_data[wr_cnt] = bus.wyj_data;
                wr_cyc[wr_cnt]  = ecnt - e0;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (bus.done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = ecnt - e0;
        end
        if (!a_rst) begin
            if (bus.sel_FSM_mux_wej !== bus.busy) inv_err = inv_err + 1;
            if (bus.busy === 1'b1 && (cur_n == 0 || int'(bus.probka_addr) > cur_n - 1))
                inv_err = inv_err + 1;
            if (bus.busy === 1'b0 &&
                (bus.wyj_wr !== 1'b0 || bus.probka_addr !== '0 || bus.wsp_addr !== '0))
                inv_err = inv_err + 1;
        end
    end

    task automatic clear_mem;
        for (int i = 0; i < 64; i++) begin
            xmem[i] = '0;
            hmem[i] = '0;
        end
    endtask

    // Runs one block; optionally pulses start and perturbs N/T at cycle 'poke'
    task automatic run_block(input int n, input int t, input int poke, output bit timed_out);
        @(negedge a_clk);
        for (int i = 0; i < 64; i++) begin
            wr_addr[i] = 'x;
            wr_data[i] = 'x;
            wr_cyc[i]  = -1;
        end
        wr_cnt          = 0;
        done_cnt        = 0;
        done_cyc        = -1;
        cur_n           = n;
        bus.num_samples = 13'(n);
        bus.num_taps    = 7'(t);
        bus.start       = 1'b1;
        @(negedge a_clk);
        bus.start = 1'b0;
        timed_out = 1'b1;
        for (int i = 1; i < 4000; i++) begin
            #1;
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
            if (i == poke) begin
                bus.start       = 1'b1;
                bus.num_samples = 13'd9;
                bus.num_taps    = 7'd2;
            end else if (i == poke + 1) begin
                bus.start = 1'b0;
            end
            @(negedge a_clk);
        end
        bus.start = 1'b0;
        repeat (3) @(negedge a_clk);
    endtask

    task automatic test_reset;
        a_rst           = 1'b1;
        bus.start       = 1'b0;
        bus.num_samples = '0;
        bus.num_taps    = '0;
        repeat (3) @(negedge a_clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.sat !== 1'b0) begin failures++; $display("FAIL reset_sat: got %b expected 0", bus.sat); end
        checks++; if (bus.sel_FSM_mux_wej !== 1'b0) begin failures++; $display("FAIL reset_sel: got %b expected 0", bus.sel_FSM_mux_wej); end
        checks++; if (bus.wyj_wr !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b expected 0", bus.wyj_wr); end
        checks++; if (bus.probka_addr !== 13'h0) begin failures++; $display("FAIL reset_probka_addr: got %h expected 0", bus.probka_addr); end
        checks++; if (bus.wsp_addr !== 13'h0) begin failures++; $display("FAIL reset_wsp_addr: got %h expected 0", bus.wsp_addr); end
        checks++; if (bus.wyj_addr !== 13'h0) begin failures++; $display("FAIL reset_wyj_addr: got %h expected 0", bus.wyj_addr); end
        checks++; if (bus.wyj_data !== 16'h0) begin failures++; $display("FAIL reset_wyj_data: got %h expected 0", bus.wyj_data); end
        a_rst = 1'b0;
        repeat (2) @(negedge a_clk);
    endtask

    task automatic test_scale;
        logic [15:0] exp_y [4];
        bit to;
        exp_y = '{16'h1000, 16'h2000, 16'hE000, 16'h0000};
        clear_mem();
        hmem[0] = 16'h4000;
        xmem[0] = 16'h2000; xmem[1] = 16'h4000; xmem[2] = 16'hC000; xmem[3] = 16'h0000;
        run_block(4, 1, 0, to);
        checks++; if (to) begin failures++; $display("FAIL scale_timeout: done not seen within budget"); end
        checks++; if (wr_cnt != 4) begin failures++; $display("FAIL scale_writes: got %0d expected 4", wr_cnt); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (wr_addr[j] !== 13'(j)) begin failures++; $display("FAIL scale_addr[%0d]: got %h expected %h", j, wr_addr[j], 13'(j)); end
            checks++; if (wr_data[j] !== exp_y[j]) begin failures++; $display("FAIL scale_y[%0d]: got %h expected %h", j, wr_data[j], exp_y[j]); end
            checks++; if (wr_cyc[j] != (j + 1) * 3) begin failures++; $display("FAIL scale_cycle[%0d]: got %0d expected %0d", j, wr_cyc[j], (j + 1) * 3); end
        end
        checks++; if (done_cyc != 13) begin failures++; $display("FAIL scale_done_cycle: got %0d expected 13", done_cyc); end
        checks++; if (bus.sat !== 1'b0) begin failures++; $display("FAIL scale_sat: got %b expected 0", bus.sat); end
    endtask

    task automatic load_impulse;
        clear_mem();
        hmem[0] = 16'h1000; hmem[1] = 16'h2000; hmem[2] = 16'h3000;
        xmem[0] = 16'h7FFF;
    endtask

    task automatic check_impulse(input string tag);
        logic [15:0] exp_y [5];
        exp_y = '{16'h1000, 16'h2000, 16'h3000, 16'h0000, 16'h0000};
        checks++; if (wr_cnt != 5) begin failures++; $display("FAIL %s_writes: got %0d expected 5", tag, wr_cnt); end
        for (int j = 0; j < 5; j++) begin
            checks++; if (wr_data[j] !== exp_y[j] || wr_addr[j] !== 13'(j)) begin failures++; $display("FAIL %s_y[%0d]: got %h@%h expected %h@%h", tag, j, wr_data[j], wr_addr[j], exp_y[j], 13'(j)); end
            checks++; if (wr_cyc[j] != (j + 1) * 5) begin failures++; $display("FAIL %s_cycle[%0d]: got %0d expected %0d", tag, j, wr_cyc[j], (j + 1) * 5); end
        end
        checks++; if (done_cyc != 26) begin failures++; $display("FAIL %s_done_cycle: got %0d expected 26", tag, done_cyc); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL %s_done_count: got %0d expected 1", tag, done_cnt); end
        checks++; if (bus.sat !== 1'b0) begin failures++; $display("FAIL %s_sat: got %b expected 0", tag, bus.sat); end
    endtask

    task automatic test_impulse;
        bit to;
        load_impulse();
        run_block(5, 3, 0, to);
        checks++; if (to) begin failures++; $display("FAIL impulse_timeout: done not seen within budget"); end
        check_impulse("impulse");
    endtask

    task automatic test_saturation;
        logic [15:0] exp_y [4];
        bit to;
        exp_y = '{16'h7FFE, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        clear_mem();
        for (int i = 0; i < 4; i++) begin
            xmem[i] = 16'h7FFF;
            hmem[i] = 16'h7FFF;
        end
        run_block(4, 4, 0, to);
        checks++; if (to) begin failures++; $display("FAIL satpos_timeout: done not seen within budget"); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (wr_data[j] !== exp_y[j]) begin failures++; $display("FAIL satpos_y[%0d]: got %h expected %h", j, wr_data[j], exp_y[j]); end
        end
        checks++; if (bus.sat !== 1'b1) begin failures++; $display("FAIL satpos_sat: got %b expected 1", bus.sat); end
        clear_mem();
        xmem[0] = 16'h8000;
        hmem[0] = 16'h8000;
        run_block(1, 1, 0, to);
        checks++; if (to) begin failures++; $display("FAIL satneg_timeout: done not seen within budget"); end
        checks++; if (wr_cnt != 1 || wr_data[0] !== 16'h7FFF) begin failures++; $display("FAIL satneg_y: got %h (writes %0d) expected 7fff (writes 1)", wr_data[0], wr_cnt); end
        checks++; if (bus.sat !== 1'b1) begin failures++; $display("FAIL satneg_sat: got %b expected 1", bus.sat); end
    endtask

    task automatic test_empty;
        bit to;
        run_block(0, 3, 0, to);
        checks++; if (to || wr_cnt != 0) begin failures++; $display("FAIL empty_n_writes: got %0d (timeout %0b) expected 0", wr_cnt, to); end
        checks++; if (done_cyc != 1) begin failures++; $display("FAIL empty_n_done_cycle: got %0d expected 1", done_cyc); end
        run_block(3, 0, 0, to);
        checks++; if (to || wr_cnt != 0) begin failures++; $display("FAIL empty_t_writes: got %0d (timeout %0b) expected 0", wr_cnt, to); end
        checks++; if (done_cyc != 1) begin failures++; $display("FAIL empty_t_done_cycle: got %0d expected 1", done_cyc); end
    endtask

    task automatic test_clamp;
        bit to;
        clear_mem();
        hmem[0] = 16'h4000;
        xmem[0] = 16'h2000;
        run_block(1, 100, 0, to);
        checks++; if (to || wr_cnt != 1 || wr_data[0] !== 16'h1000) begin failures++; $display("FAIL clamp_y: got %h (writes %0d) expected 1000 (writes 1)", wr_data[0], wr_cnt); end
        checks++; if (wr_cyc[0] != 66) begin failures++; $display("FAIL clamp_write_cycle: got %0d expected 66", wr_cyc[0]); end
        checks++; if (done_cyc != 67) begin failures++; $display("FAIL clamp_done_cycle: got %0d expected 67", done_cyc); end
    endtask

    task automatic test_restart_ignored;
        bit to;
        load_impulse();
        run_block(5, 3, 7, to);
        checks++; if (to) begin failures++; $display("FAIL restart_timeout: done not seen within budget"); end
        check_impulse("restart");
    endtask

    task automatic test_reset_abort;
        load_impulse();
        @(negedge a_clk);
        wr_cnt          = 0;
        done_cnt        = 0;
        cur_n           = 5;
        bus.num_samples = 13'd5;
        bus.num_taps    = 7'd3;
        bus.start       = 1'b1;
        @(negedge a_clk);
        bus.start = 1'b0;
        repeat (6) @(negedge a_clk);
        #1 a_rst = 1'b1;
        @(negedge a_clk);
        checks++; if (bus.busy !== 1'b0 || bus.sel_FSM_mux_wej !== 1'b0) begin failures++; $display("FAIL abort_busy: got busy=%b sel=%b expected 0/0", bus.busy, bus.sel_FSM_mux_wej); end
        checks++; if (bus.probka_addr !== 13'h0 || bus.wyj_data !== 16'h0) begin failures++; $display("FAIL abort_outputs: got addr=%h data=%h expected 0/0", bus.probka_addr, bus.wyj_data); end
        #1 a_rst = 1'b0;
        repeat (40) @(negedge a_clk);
        #1;
        checks++; if (wr_cnt != 1) begin failures++; $display("FAIL abort_writes: got %0d expected 1", wr_cnt); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
    endtask

    task automatic test_invariants;
        checks++; if (inv_err != 0) begin failures++; $display("FAIL invariants: got %0d violations expected 0", inv_err); end
    endtask

    initial begin
        clear_mem();
        bus.start       = 1'b0;
        bus.num_samples = '0;
        bus.num_taps    = '0;
        test_reset();
        test_scale();
        test_impulse();
        test_saturation();
        test_empty();
        test_clamp();
        test_restart_ignored();
        test_reset_abort();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
